// File: rtl/id_pkg.sv
// Shared definitions for the decode/register-read stage.
//   imm_type_e : immediate format selector driven by the instruction decoder
//   *_LSB      : bit positions of the register fields inside an RV32 instruction
//   imm_gen    : RV32I immediate extraction, sign-extended to 32 bits
package id_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  localparam int REG_FIELD_W = 5;
  localparam int RD_LSB      = 7;
  localparam int RS1_LSB     = 15;
  localparam int RS2_LSB     = 20;

  // Returns a 32-bit sign-correct immediate; the caller sign-extends it to XLEN.
  // Any encoding outside the enum falls back to the I format.
  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_type_e imm_type);
    logic [31:0] imm;
    case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_stage_regfile_bypass.sv
// Register file with write-to-read bypass.
//   clk, rst_n         : clock, asynchronous active-low reset (clears all registers)
//   rs1, rs2           : read addresses
//   rs1_data, rs2_data : combinational read data
//   wb_en/wb_reg/wb_data : synchronous write port; writes to register 0 are dropped
module regfile_bypass #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RW-1:0]   rs1,
  input  logic [RW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [RW-1:0]   wb_reg,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] regs_r [NREG];

  // Storage write port; register 0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wb_en && (wb_reg != '0)) begin
      regs_r[wb_reg] <= wb_data;
    end
  end

  // Read port 1: x0 reads zero, a same-cycle writeback to the addressed register is forwarded.
  always_comb begin
    rs1_data = '0;
    if (rs1 == '0) begin
      rs1_data = '0;
    end else if (wb_en && (wb_reg == rs1)) begin
      rs1_data = wb_data;
    end else begin
      rs1_data = regs_r[rs1];
    end
  end

  // Read port 2: same rules as read port 1.
  always_comb begin
    rs2_data = '0;
    if (rs2 == '0) begin
      rs2_data = '0;
    end else if (wb_en && (wb_reg == rs2)) begin
      rs2_data = wb_data;
    end else begin
      rs2_data = regs_r[rs2];
    end
  end

endmodule

// File: rtl/id_stage.sv
// Decode / register-read stage feeding the ID/EX pipeline register.
//   Inputs : IF/ID instruction, valid, next_pc, decoder ctrl bundle, imm_type,
//            operand-use flags, pc_src_sel, stall_mem, flush, writeback port,
//            rd_en_ex (EX-stage instruction is a load).
//   Outputs: hazard (combinational load-use stall request) and the registered
//            ID/EX fields opa/rs2_data/imm/next_pc, rs1/rs2/rd, ctrl, valid.
module id_stage
  import id_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int CTRL_W = 24,
  localparam int RW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic [XLEN-1:0]   next_pc,
  input  logic [CTRL_W-1:0] ctrl,
  input  imm_type_e         imm_type,
  input  logic              uses_rs1,
  input  logic              uses_rs2,
  input  logic              pc_src_sel,
  input  logic              stall_mem,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [RW-1:0]     wb_reg,
  input  logic [XLEN-1:0]   wb_data,
  output logic              hazard,
  output logic [XLEN-1:0]   opa_ex,
  output logic [XLEN-1:0]   rs2_data_ex,
  output logic [XLEN-1:0]   imm_ex,
  output logic [XLEN-1:0]   next_pc_ex,
  output logic [RW-1:0]     rs1_ex,
  output logic [RW-1:0]     rs2_ex,
  output logic [RW-1:0]     rd_ex,
  output logic [CTRL_W-1:0] ctrl_ex,
  output logic              valid_ex,
  input  logic              rd_en_ex
);

  logic [RW-1:0]     rs1_idx_s, rs2_idx_s, rd_idx_s;
  logic [XLEN-1:0]   rs1_data_s, rs2_data_s, imm_s, opa_s;
  logic              hazard_s, bubble_s;

  logic [XLEN-1:0]   opa_r, rs2_data_r, imm_r, next_pc_r;
  logic [RW-1:0]     rs1_r, rs2_r, rd_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic              valid_r;

  // The 5-bit instruction fields are resized to the configured index width.
  assign rs1_idx_s = RW'(instr[RS1_LSB +: REG_FIELD_W]);
  assign rs2_idx_s = RW'(instr[RS2_LSB +: REG_FIELD_W]);
  assign rd_idx_s  = RW'(instr[RD_LSB  +: REG_FIELD_W]);

  regfile_bypass #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1      (rs1_idx_s),
    .rs2      (rs2_idx_s),
    .rs1_data (rs1_data_s),
    .rs2_data (rs2_data_s),
    .wb_en    (wb_en),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data)
  );

  // Signed size cast sign-extends the 32-bit immediate to XLEN.
  assign imm_s = XLEN'($signed(imm_gen(instr, imm_type)));
  assign opa_s = pc_src_sel ? next_pc : rs1_data_s;

  // Load in EX whose destination is read by the instruction in ID.
  assign hazard_s = instr_valid && valid_r && rd_en_ex && (rd_r != '0) &&
                    ((uses_rs1 && (rd_r == rs1_idx_s)) ||
                     (uses_rs2 && (rd_r == rs2_idx_s)));
  assign hazard   = hazard_s;
  assign bubble_s = flush || hazard_s || !instr_valid;

  // ID/EX register: a memory stall holds everything and outranks flush/hazard bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_r      <= '0;
      rs2_data_r <= '0;
      imm_r      <= '0;
      next_pc_r  <= '0;
      rs1_r      <= '0;
      rs2_r      <= '0;
      rd_r       <= '0;
      ctrl_r     <= '0;
      valid_r    <= 1'b0;
    end else if (!stall_mem) begin
      if (bubble_s) begin
        opa_r      <= '0;
        rs2_data_r <= '0;
        imm_r      <= '0;
        next_pc_r  <= '0;
        rs1_r      <= '0;
        rs2_r      <= '0;
        rd_r       <= '0;
        ctrl_r     <= '0;
        valid_r    <= 1'b0;
      end else begin
        opa_r      <= opa_s;
        rs2_data_r <= rs2_data_s;
        imm_r      <= imm_s;
        next_pc_r  <= next_pc;
        rs1_r      <= rs1_idx_s;
        rs2_r      <= rs2_idx_s;
        rd_r       <= rd_idx_s;
        ctrl_r     <= ctrl;
        valid_r    <= 1'b1;
      end
    end
  end

  assign opa_ex      = opa_r;
  assign rs2_data_ex = rs2_data_r;
  assign imm_ex      = imm_r;
  assign next_pc_ex  = next_pc_r;
  assign rs1_ex      = rs1_r;
  assign rs2_ex      = rs2_r;
  assign rd_ex       = rd_r;
  assign ctrl_ex     = ctrl_r;
  assign valid_ex    = valid_r;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: each cycle the expected ID/EX contents are
// computed from a reference register-file model and pushed, then popped and
// compared after the clock edge.
module tb_id_stage;
  import id_pkg::*;

  localparam int XLEN = 32, NREG = 32, CTRL_W = 24, RW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       instr;
  logic              instr_valid;
  logic [XLEN-1:0]   next_pc;
  logic [CTRL_W-1:0] ctrl;
  imm_type_e         imm_type;
  logic              uses_rs1, uses_rs2, pc_src_sel, stall_mem, flush, wb_en, rd_en_ex;
  logic [RW-1:0]     wb_reg;
  logic [XLEN-1:0]   wb_data;
  logic              hazard, valid_ex;
  logic [XLEN-1:0]   opa_ex, rs2_data_ex, imm_ex, next_pc_ex;
  logic [RW-1:0]     rs1_ex, rs2_ex, rd_ex;
  logic [CTRL_W-1:0] ctrl_ex;

  typedef struct packed {
    logic        valid;
    logic [31:0] opa;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [31:0] npc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [23:0] ctrl;
  } idex_t;

  idex_t       exp_q [$];
  idex_t       model_r;
  logic [31:0] rf_m [32];
  int          n_checks = 0;
  int          n_pass   = 0;

  id_stage #(.XLEN(XLEN), .NREG(NREG), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .next_pc(next_pc), .ctrl(ctrl), .imm_type(imm_type), .uses_rs1(uses_rs1),
    .uses_rs2(uses_rs2), .pc_src_sel(pc_src_sel), .stall_mem(stall_mem),
    .flush(flush), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .hazard(hazard), .opa_ex(opa_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex),
    .next_pc_ex(next_pc_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .ctrl_ex(ctrl_ex), .valid_ex(valid_ex), .rd_en_ex(rd_en_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // Reference immediate built with arithmetic shifts and masks.
  function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [2:0] t);
    logic [31:0] sx;
    case (t)
      3'd1: begin
        sx = 32'($signed(i) >>> 20);
        ref_imm = (sx & 32'hFFFF_FFE0) | 32'(i[11:7]);
      end
      3'd2: begin
        sx = 32'($signed(i) >>> 19);
        ref_imm = (sx & 32'hFFFF_F000) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      end
      3'd3: ref_imm = i & 32'hFFFF_F000;
      3'd4: begin
        sx = 32'($signed(i) >>> 11);
        ref_imm = (sx & 32'hFFF0_0000) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      end
      default: ref_imm = 32'($signed(i) >>> 20);
    endcase
  endfunction

  function automatic logic [31:0] ref_rd(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_en && wb_reg == r) return wb_data;
    return rf_m[r];
  endfunction

  task automatic set_instr(input logic [31:0] i, input imm_type_e t, input logic u1, input logic u2,
                           input logic psel, input logic [23:0] c, input logic [31:0] npc);
    instr = i; imm_type = t; uses_rs1 = u1; uses_rs2 = u2; pc_src_sel = psel;
    ctrl = c; next_pc = npc; instr_valid = 1'b1;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_reg = r; wb_data = d;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(valid_ex), 64'd0);
    chk({tag, "_opa"},   64'(opa_ex), 64'd0);
    chk({tag, "_rs2d"},  64'(rs2_data_ex), 64'd0);
    chk({tag, "_imm"},   64'(imm_ex), 64'd0);
    chk({tag, "_npc"},   64'(next_pc_ex), 64'd0);
    chk({tag, "_idx"},   64'({rs1_ex, rs2_ex, rd_ex}), 64'd0);
    chk({tag, "_ctrl"},  64'(ctrl_ex), 64'd0);
  endtask

  // One clock: check hazard, push expected ID/EX, update model RF, clock, pop and compare.
  task automatic cycle();
    idex_t nxt, e;
    logic  hz;
    logic [4:0] r1, r2;
    #1;
    r1 = instr[19:15];
    r2 = instr[24:20];
    hz = instr_valid && model_r.valid && rd_en_ex && (model_r.rd != 5'd0) &&
         ((uses_rs1 && model_r.rd == r1) || (uses_rs2 && model_r.rd == r2));
    chk("hazard", 64'(hazard), 64'(hz));
    if (stall_mem) nxt = model_r;
    else if (flush || hz || !instr_valid) nxt = '0;
    else begin
      nxt.valid = 1'b1;
      nxt.opa   = pc_src_sel ? next_pc : ref_rd(r1);
      nxt.rs2d  = ref_rd(r2);
      nxt.imm   = ref_imm(instr, imm_type);
      nxt.npc   = next_pc;
      nxt.rs1   = r1;
      nxt.rs2   = r2;
      nxt.rd    = instr[11:7];
      nxt.ctrl  = ctrl;
    end
    exp_q.push_back(nxt);
    if (wb_en && wb_reg != 5'd0) rf_m[wb_reg] = wb_data;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("valid_ex",    64'(valid_ex), 64'(e.valid));
    chk("opa_ex",      64'(opa_ex), 64'(e.opa));
    chk("rs2_data_ex", 64'(rs2_data_ex), 64'(e.rs2d));
    chk("imm_ex",      64'(imm_ex), 64'(e.imm));
    chk("next_pc_ex",  64'(next_pc_ex), 64'(e.npc));
    chk("rs1_ex",      64'(rs1_ex), 64'(e.rs1));
    chk("rs2_ex",      64'(rs2_ex), 64'(e.rs2));
    chk("rd_ex",       64'(rd_ex), 64'(e.rd));
    chk("ctrl_ex",     64'(ctrl_ex), 64'(e.ctrl));
    model_r = e;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    model_r = '0;
    rst_n = 1'b0; instr = 32'd0; instr_valid = 1'b0; next_pc = 32'd0; ctrl = 24'd0;
    imm_type = IMM_I; uses_rs1 = 1'b0; uses_rs2 = 1'b0; pc_src_sel = 1'b0;
    stall_mem = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_reg = 5'd0; wb_data = 32'd0; rd_en_ex = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Preload x1..x7 with bubbles in ID.
    for (int r = 1; r < 8; r++) begin
      wb(5'(r), 32'h1000_0000 + 32'(r) * 32'h0101);
      cycle();
    end
    wb_en = 1'b0;

    // Bypass: add x1,x3,x0 while x3 is written back.
    set_instr(32'h0001_80B3, IMM_I, 1'b1, 1'b1, 1'b0, 24'h00_0011, 32'h0000_0104);
    wb(5'd3, 32'hDEAD_BEEF);
    cycle();
    chk("bypass_opa", 64'(opa_ex), 64'h0000_0000_DEAD_BEEF);
    wb_en = 1'b0;

    // x0: attempted write, then read rs1=0.
    instr_valid = 1'b0;
    wb(5'd0, 32'h0000_1234);
    cycle();
    wb_en = 1'b0;
    set_instr(32'h0000_0133, IMM_I, 1'b1, 1'b1, 1'b0, 24'h00_0022, 32'h0000_0108);
    cycle();
    chk("x0_opa", 64'(opa_ex), 64'd0);

    // Load-use: lw x4 into EX, then dependent add x5,x4,x1.
    set_instr(32'h0000_A203, IMM_I, 1'b1, 1'b0, 1'b0, 24'h00_0001, 32'h0000_010C);
    cycle();
    chk("lw_rd", 64'(rd_ex), 64'd4);
    set_instr(32'h0012_02B3, IMM_I, 1'b1, 1'b1, 1'b0, 24'h00_ABCD, 32'h0000_0110);
    rd_en_ex = 1'b1;
    #1;
    chk("lu_hazard_hi", 64'(hazard), 64'd1);
    cycle();
    chk("lu_bubble_valid", 64'(valid_ex), 64'd0);
    chk("lu_bubble_ctrl", 64'(ctrl_ex), 64'd0);
    rd_en_ex = 1'b0;
    #1;
    chk("lu_hazard_lo", 64'(hazard), 64'd0);
    cycle();
    chk("lu_add_valid", 64'(valid_ex), 64'd1);
    chk("lu_add_rd", 64'(rd_ex), 64'd5);

    // Immediates.
    set_instr(32'hFE00_0EE3, IMM_B, 1'b1, 1'b1, 1'b0, 24'h00_0033, 32'h0000_0114);
    cycle();
    chk("imm_b", 64'(imm_ex), 64'h0000_0000_FFFF_FFFC);
    set_instr(32'h8000_00EF, IMM_J, 1'b0, 1'b0, 1'b1, 24'h00_0044, 32'h0000_0118);
    cycle();
    chk("imm_j", 64'(imm_ex), 64'h0000_0000_FFF0_0000);
    chk("jal_opa", 64'(opa_ex), 64'h0000_0000_0000_0118);

    // Priority: stall with flush holds, then flush alone bubbles; writes continue under stall.
    set_instr(32'h0020_8333, IMM_I, 1'b1, 1'b1, 1'b1, 24'h00_0055, 32'hCAFE_0000);
    cycle();
    stall_mem = 1'b1; flush = 1'b1;
    set_instr(32'h0000_0013, IMM_U, 1'b0, 1'b0, 1'b0, 24'h00_0066, 32'h0000_0200);
    wb(5'd7, 32'h7777_7777);
    cycle();
    cycle();
    chk("stall_valid", 64'(valid_ex), 64'd1);
    chk("stall_opa", 64'(opa_ex), 64'h0000_0000_CAFE_0000);
    chk("stall_ctrl", 64'(ctrl_ex), 64'h55);
    stall_mem = 1'b0; wb_en = 1'b0;
    cycle();
    chk("flush_valid", 64'(valid_ex), 64'd0);
    flush = 1'b0;
    set_instr(32'h0003_8433, IMM_I, 1'b1, 1'b0, 1'b0, 24'h00_0077, 32'h0000_0204);
    cycle();
    chk("stall_wb_x7", 64'(opa_ex), 64'h0000_0000_7777_7777);

    // Random traffic through the scoreboard.
    for (int n = 0; n < 80; n++) begin
      instr = $urandom;
      imm_type = imm_type_e'(3'($urandom_range(0, 7)));
      uses_rs1 = 1'($urandom); uses_rs2 = 1'($urandom); pc_src_sel = 1'($urandom);
      instr_valid = ($urandom_range(0, 7) != 0);
      ctrl = 24'($urandom); next_pc = $urandom;
      stall_mem = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rd_en_ex = 1'($urandom);
      wb_en = 1'($urandom); wb_reg = 5'($urandom); wb_data = $urandom;
      cycle();
    end
    stall_mem = 1'b0; flush = 1'b0; rd_en_ex = 1'b0;

    // Mid-stream asynchronous reset, then read x5 after release.
    wb(5'd5, 32'h5555_5555);
    set_instr(32'h0020_8333, IMM_S, 1'b1, 1'b1, 1'b0, 24'h00_0088, 32'h0000_0300);
    cycle();
    wb_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    model_r = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_instr(32'h0002_84B3, IMM_I, 1'b1, 1'b0, 1'b0, 24'h00_0099, 32'h0000_0304);
    cycle();
    chk("post_rst_x5", 64'(opa_ex), 64'd0);
    chk("post_rst_valid", 64'(valid_ex), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
